// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares the single SDRAM-controller burst port between the video-in write
// requester and the video-out read requester. Both sides use the hold/holda
// burst handshake. Arbitration is round-robin. The winner's length and
// address are latched at grant. holda is forwarded only to the granted side.
// The number of delivered beats is checked against the latched length.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a grant that sees no holda within TIMEOUT cycles enters
//   ABORT. ABORT drops hold and sets the sticky to_err flag. When the macro
//   is undefined, to_err is tied low and a grant waits indefinitely.
//
// Ports (sys_clk domain, synchronous active-high rst)
//   wr_hold / wr_burst_length / wr_burst_address / wr_burst_data
//                         write requester request, length, address and data
//   wr_holda              beat strobe back to the write requester
//   rd_hold / rd_burst_length / rd_burst_address
//                         read requester request, length and address
//   rd_holda              beat strobe back to the read requester
//   hold, burst_rw, burst_length, burst_address, burst_data
//                         request to the RAM controller (rw: 0=write, 1=read)
//   holda                 RAM controller beat strobe, one word per cycle
//   len_err               sticky beat-count mismatch
//   to_err                sticky first-beat timeout
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int LEN_W   = 9,
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              wr_hold,
    input  logic [LEN_W-1:0]  wr_burst_length,
    input  logic [ADDR_W-1:0] wr_burst_address,
    input  logic [DATA_W-1:0] wr_burst_data,
    output logic              wr_holda,
    input  logic              rd_hold,
    input  logic [LEN_W-1:0]  rd_burst_length,
    input  logic [ADDR_W-1:0] rd_burst_address,
    output logic              rd_holda,
    output logic              hold,
    output logic              burst_rw,
    output logic [LEN_W-1:0]  burst_length,
    output logic [ADDR_W-1:0] burst_address,
    output logic [DATA_W-1:0] burst_data,
    input  logic              holda,
    output logic              len_err,
    output logic              to_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GNT_WR = 2'd1;
    localparam logic [1:0] GNT_RD = 2'd2;
`ifdef ARB_TIMEOUT_EN
    localparam logic [1:0] ABORT  = 2'd3;
    localparam int         WAIT_W = $clog2(TIMEOUT + 1);
`endif

    logic [1:0]        state_q, state_d;
    logic              last_rd_q, last_rd_d;
    logic              rw_q, rw_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              len_err_q, len_err_d;
`ifdef ARB_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              to_err_q, to_err_d;
`endif

    // rw_q names the current owner for the whole grant (and ABORT), so it
    // also selects whose hold decides the release.
    logic owner_hold;
    assign owner_hold = rw_q ? rd_hold : wr_hold;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        last_rd_d  = last_rd_q;
        rw_d       = rw_q;
        len_d      = len_q;
        addr_d     = addr_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        to_err_d   = to_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (wr_hold || rd_hold) begin
                    // Write wins when alone, or on a tie when read went last.
                    if (wr_hold && (!rd_hold || last_rd_q)) begin
                        state_d   = GNT_WR;
                        rw_d      = 1'b0;
                        last_rd_d = 1'b0;
                        len_d     = wr_burst_length;
                        addr_d    = wr_burst_address;
                    end else begin
                        state_d   = GNT_RD;
                        rw_d      = 1'b1;
                        last_rd_d = 1'b1;
                        len_d     = rd_burst_length;
                        addr_d    = rd_burst_address;
                    end
                    beat_cnt_d = '0;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            GNT_WR, GNT_RD: begin
                if (!owner_hold && !holda) begin
                    state_d = IDLE;
                    if (beat_cnt_q != len_q) len_err_d = 1'b1;
                end else if (holda) begin
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + LEN_W'(1);
`ifdef ARB_TIMEOUT_EN
                end else if (beat_cnt_q == '0) begin
                    // beat_cnt never returns to zero within a grant, so zero
                    // means the first holda has not yet arrived.
                    if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_d  = ABORT;
                        to_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
`endif
                end
            end
`ifdef ARB_TIMEOUT_EN
            ABORT: begin
                if (!owner_hold) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_rd_q  <= 1'b1;
            rw_q       <= 1'b0;
            len_q      <= '0;
            addr_q     <= '0;
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
            to_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            last_rd_q  <= last_rd_d;
            rw_q       <= rw_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            to_err_q   <= to_err_d;
`endif
        end
    end

    assign hold          = (state_q == GNT_WR) || (state_q == GNT_RD);
    assign burst_rw      = rw_q;
    assign burst_length  = len_q;
    assign burst_address = addr_q;
    assign wr_holda      = (state_q == GNT_WR) && holda;
    assign rd_holda      = (state_q == GNT_RD) && holda;
    assign burst_data    = (state_q == GNT_WR) ? wr_burst_data : '0;
    assign len_err       = len_err_q;

`ifdef ARB_TIMEOUT_EN
    assign to_err = to_err_q;
`else
    assign to_err = 1'b0;
    // TIMEOUT only configures the optional timeout path.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule
